spectrum_line_feeder: RTL and testbench
=======================================

# spectrum_line_feeder

Buffers one frame of FFT output as 64 per-line bar lengths and serves them to the LCD bar renderer. It sits between the FFT core and the LCD renderer (`lcd_display`). On the FFT side it converts complex bins to an approximate magnitude, scales it to pixels and stores it in a ping-pong buffer. On the LCD side it drives `line_cnt` and `line_length`, advancing on the renderer's `wr_over` pulse and swapping banks only at frame sync, so a displayed frame never tears.

## Interface
- `N_BINS`, 64: bins stored per frame (positive-frequency half of a 128-point FFT).
- `H_LCD_DISP`, 480: visible width; `line_length` clamps to `H_LCD_DISP-1`.
- `MAG_SHIFT`, 6: right shift applied to the magnitude before clamping.
- `lcd_clk`  in  1  sole clock (FFT and LCD sides share it).
- `sys_rst`  in  1  asynchronous, active-low reset.
- `fft_valid`  in  1  bin qualifier.
- `fft_sop`  in  1  with `fft_valid`: first bin of a frame.
- `fft_eop`  in  1  with `fft_valid`: last bin of a frame (bin 127).
- `fft_re`, `fft_im`  in  16 each  signed two's-complement bin.
- `frame_sync`  in  1  one-cycle pulse at LCD frame start (`pixel_ypos==0`, `pixel_xpos==0`).
- `wr_over`  in  1  renderer pulse: current line finished.
- `line_cnt`  out  7  line index, 0..63.
- `line_length`  out  16  bar length in pixels for `line_cnt`.
- `frame_drop`  out  1  one-cycle pulse when a malformed FFT frame is discarded.

## Operation
- **Magnitude:**
  - `a=|re|`, `b=|im|`, each saturated to 16 bits (−32768 maps to 32767).
  - `mag = max(a,b) + (min(a,b)>>1)`, 17 bits unsigned.
  - `len = min(mag>>MAG_SHIFT, H_LCD_DISP-1)`, zero-extended to 16 bits.
- **Write side:**
  - `bin_idx` is 7 bits. It loads 0 on `fft_valid&fft_sop` and increments on each valid bin.
  - Bins with `bin_idx<N_BINS` are written to `bank[wr_bank][bin_idx]`. Bins 64..127 are not stored.
- **Write FSM:** `IDLE` → (`valid&sop`) → `FILL` → (`valid&eop` with `bin_idx==127`) → `IDLE` and `ready<=1`.
  - `ready` clears on every accepted sop.
  - `fft_valid&sop` while in `FILL` restarts the frame: pulse `frame_drop`, keep `ready` cleared.
  - `valid&eop` with `bin_idx!=127`: pulse `frame_drop`, go to `IDLE`, `ready` stays 0.
  - Valid bins while in `IDLE` without sop are ignored.
- **Read side:**
  - `frame_sync` resets `line_cnt` to 0.
  - At `frame_sync`, if `ready==1`: `rd_bank<=wr_bank`, `wr_bank<=~wr_bank`, `ready<=0`, `shown<=1`.
  - `wr_over` increments `line_cnt`, saturating at 63 (extra pulses hold 63).
  - `line_length <= shown ? bank[rd_bank][line_cnt] : 0`, registered.
- **Simultaneous events:**
  - `frame_sync` and `wr_over` in the same cycle: `frame_sync` wins.
  - Frame completion (`ready` set) and `frame_sync` in the same cycle: the swap is not taken that sync; it happens at the next sync.
  - A newer complete frame arriving before a sync overwrites the write bank. Newest wins; no drop pulse.

## Timing
- **Reset values:** `line_cnt=0`, `line_length=0`, `frame_drop=0`, `wr_bank=0`, `rd_bank=1`, `ready=0`, `shown=0`, FSM `IDLE`. Buffer contents are not reset.
- **Write pipeline:** 2 stages (abs; max/min/add/shift/clamp + write). A bin is written 2 cycles after its `fft_valid`. `ready` sets in the cycle of the last write, i.e. eop + 2.
- **Read path:**
  - `line_cnt` updates the cycle after `wr_over`/`frame_sync`.
  - `line_length` is valid 2 cycles after `wr_over` (1-cycle synchronous RAM read).
  - This is well inside the 480-clock row before the renderer samples it.
- **Bank access:** reads and writes always target different banks, so there is no read/write collision.
- **Reset mid-operation:** all state returns to reset values asynchronously. A partial frame is lost without a `frame_drop` pulse.

## Structure
- **Shared package `fftpga_pkg`:** `N_BINS`, `H_LCD_DISP`, the widths `BIN_W=16` and `LEN_W=16`, and the write-FSM state enum (`IDLE`, `FILL`).
- **Sub-module `mag_approx`:** the two-stage abs/max-min/shift/clamp pipeline with `valid`/`sop`/`eop` sideband. It is also reusable for a future peak-hold block.
- **Buffer:** two 64×16 simple dual-port RAMs, or one 128×16 RAM with the bank as the address MSB.

## Test plan
- Reset, then `frame_sync` and 64 `wr_over` pulses with no FFT input → `line_length==0` throughout; `line_cnt` runs 0..63 and holds at 63.
- **Magnitude:** full frame with bin k = (re=k·256, im=0) → after sync, line k shows `(k·256)>>6 = 4k`. Bin 3 with re=−32768, im=−32768 → 479 (clamped).
- **Approximation:** re=3000, im=−4000 → mag 5500, `line_length` 85.
- **Torn-frame guard:**
  - Start frame A, fire `frame_sync` mid-frame → display keeps the old bank.
  - A completes; next sync → A shown.
  - `line_length` appears 2 cycles after each `wr_over`.
- **Malformed frames:**
  - eop at bin 50 → `frame_drop` pulse, no swap at next sync.
  - sop at bin 90 of a frame → `frame_drop` pulse, then the restarted frame swaps in normally.
- **Priority and reset:**
  - `frame_sync` coincident with `wr_over` → `line_cnt==0`.
  - Two complete frames between syncs → the second is displayed.
  - `sys_rst` asserted mid-fill → all outputs at reset values the same cycle.

Source files
------------

// File: rtl/fftpga_pkg.sv
// fftpga_pkg: shared sizes, write-FSM states and saturating abs helper for the FFT display path
package fftpga_pkg;
    localparam int N_BINS = 64;
    localparam int H_LCD_DISP = 480;
    localparam int BIN_W = 16;
    localparam int LEN_W = 16;
    typedef enum logic {IDLE, FILL} wr_state_t;
    function automatic logic [BIN_W-1:0] sat_abs(input logic signed [BIN_W-1:0] x);
        return !x[BIN_W-1] ? x :
               (x == {1'b1, {(BIN_W-1){1'b0}}}) ? {1'b0, {(BIN_W-1){1'b1}}} : BIN_W'(-x);
    endfunction
endpackage

// File: rtl/mag_approx.sv
// mag_approx: two-stage |re|,|im| -> max+min/2 -> shift -> clamp pipeline with frame sideband
module mag_approx
    import fftpga_pkg::*;
#(
    parameter int MAG_SHIFT = 6,
    parameter int LEN_MAX = fftpga_pkg::H_LCD_DISP - 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid,
    input  logic                    sop,
    input  logic                    eop,
    input  logic signed [BIN_W-1:0] re,
    input  logic signed [BIN_W-1:0] im,
    output logic                    len_valid,
    output logic                    len_sop,
    output logic                    len_eop,
    output logic [LEN_W-1:0]        len
);
    logic [BIN_W-1:0] a, b, mx, mn;
    logic [BIN_W:0] mag, sh;
    logic s1_valid, s1_sop, s1_eop;
    assign mx = (a > b) ? a : b;
    assign mn = (a > b) ? b : a;
    assign mag = {1'b0, mx} + {2'b0, mn[BIN_W-1:1]};
    assign sh = mag >> MAG_SHIFT;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s1_valid, s1_sop, s1_eop} <= '0;
            {len_valid, len_sop, len_eop} <= '0;
            a <= '0;
            b <= '0;
            len <= '0;
        end else begin
            {s1_valid, s1_sop, s1_eop} <= {valid, valid & sop, valid & eop};
            a <= sat_abs(re);
            b <= sat_abs(im);
            {len_valid, len_sop, len_eop} <= {s1_valid, s1_sop, s1_eop};
            len <= (sh > (BIN_W+1)'(LEN_MAX)) ? LEN_W'(LEN_MAX) : LEN_W'(sh);
        end
    end
endmodule

// File: rtl/spectrum_line_feeder.sv
// spectrum_line_feeder: ping-pong buffer of per-line bar lengths between FFT and LCD renderer.
// Banks swap only at frame sync, so a displayed frame never tears.
module spectrum_line_feeder
    import fftpga_pkg::*;
#(
    parameter int N_BINS = fftpga_pkg::N_BINS,
    parameter int H_LCD_DISP = fftpga_pkg::H_LCD_DISP,
    parameter int MAG_SHIFT = 6
) (
    input  logic                    lcd_clk,
    input  logic                    sys_rst,
    input  logic                    fft_valid,
    input  logic                    fft_sop,
    input  logic                    fft_eop,
    input  logic signed [BIN_W-1:0] fft_re,
    input  logic signed [BIN_W-1:0] fft_im,
    input  logic                    frame_sync,
    input  logic                    wr_over,
    output logic [6:0]              line_cnt,
    output logic [LEN_W-1:0]        line_length,
    output logic                    frame_drop
);
    localparam int AW = $clog2(N_BINS);
    localparam logic [6:0] LAST_BIN = 7'(2*N_BINS - 1);
    localparam logic [6:0] LAST_LINE = 7'(N_BINS - 1);
    logic p_valid, p_sop, p_eop;
    logic [LEN_W-1:0] p_len;
    logic [LEN_W-1:0] mem [2*N_BINS];
    wr_state_t state, state_nx;
    logic [6:0] bin_idx, cur_idx;
    logic wr_bank, rd_bank, ready, shown, ready_nx, drop_nx, active, swap, wr_en;

    mag_approx #(.MAG_SHIFT(MAG_SHIFT), .LEN_MAX(H_LCD_DISP - 1)) u_mag (
        .clk(lcd_clk), .rst_n(sys_rst),
        .valid(fft_valid), .sop(fft_sop), .eop(fft_eop), .re(fft_re), .im(fft_im),
        .len_valid(p_valid), .len_sop(p_sop), .len_eop(p_eop), .len(p_len)
    );

    assign swap = frame_sync & ready;
    assign wr_en = active & (cur_idx < 7'(N_BINS));

    // The FSM follows the pipeline output, so index and data stay aligned.
    always_comb begin
        cur_idx = p_sop ? '0 : bin_idx;
        active = p_valid & (p_sop | (state == FILL));
        state_nx = active ? (p_eop ? IDLE : FILL) : state;
        drop_nx = active & ((p_sop & (state == FILL)) | (p_eop & (cur_idx != LAST_BIN)));
        ready_nx = (swap | (active & p_sop)) ? 1'b0 : ready;
        if (active & p_eop & (cur_idx == LAST_BIN))
            ready_nx = 1'b1;
    end

    always_ff @(posedge lcd_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= IDLE;
            bin_idx <= '0;
            ready <= 1'b0;
            frame_drop <= 1'b0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b1;
            shown <= 1'b0;
            line_cnt <= '0;
            line_length <= '0;
        end else begin
            state <= state_nx;
            bin_idx <= active ? cur_idx + 7'd1 : bin_idx;
            ready <= ready_nx;
            frame_drop <= drop_nx;
            wr_bank <= swap ? ~wr_bank : wr_bank;
            rd_bank <= swap ? wr_bank : rd_bank;
            shown <= shown | swap;
            line_cnt <= frame_sync ? '0 : (wr_over && line_cnt != LAST_LINE) ? line_cnt + 7'd1 : line_cnt;
            line_length <= shown ? mem[{rd_bank, line_cnt[AW-1:0]}] : '0;
        end
    end

    always_ff @(posedge lcd_clk)
        if (wr_en)
            mem[{wr_bank, cur_idx[AW-1:0]}] <= p_len;
endmodule

// File: tb/tb_spectrum_line_feeder.sv
// tb_spectrum_line_feeder: directed scenarios for the spectrum line feeder with hand-computed bar lengths
module tb_spectrum_line_feeder;
    logic lcd_clk = 1'b0;
    logic sys_rst = 1'b0;
    logic fft_valid = 1'b0, fft_sop = 1'b0, fft_eop = 1'b0;
    logic signed [15:0] fft_re = '0, fft_im = '0;
    logic frame_sync = 1'b0, wr_over = 1'b0;
    logic [6:0] line_cnt;
    logic [15:0] line_length;
    logic frame_drop;
    int checks = 0, errors = 0, drops = 0, d0;
    logic signed [15:0] fre [128];
    logic signed [15:0] fim [128];
    logic [15:0] got [64];
    logic [6:0] gcnt [64];

    always #5 lcd_clk = ~lcd_clk;

    spectrum_line_feeder dut (
        .lcd_clk(lcd_clk), .sys_rst(sys_rst),
        .fft_valid(fft_valid), .fft_sop(fft_sop), .fft_eop(fft_eop),
        .fft_re(fft_re), .fft_im(fft_im),
        .frame_sync(frame_sync), .wr_over(wr_over),
        .line_cnt(line_cnt), .line_length(line_length), .frame_drop(frame_drop)
    );

    always @(posedge lcd_clk) if (sys_rst && frame_drop === 1'b1) drops++;

    task automatic step;
        @(posedge lcd_clk);
        #1;
    endtask

    task automatic fill(input int base, input int inc);
        for (int i = 0; i < 128; i++) begin
            fre[i] = 16'(base + i*inc);
            fim[i] = '0;
        end
    endtask

    task automatic send_bins(input int first, input int n, input bit sop, input bit eop);
        for (int i = 0; i < n; i++) begin
            fft_valid = 1'b1;
            fft_sop = sop && (i == 0);
            fft_eop = eop && (i == n-1);
            fft_re = fre[first+i];
            fft_im = fim[first+i];
            step;
        end
        {fft_valid, fft_sop, fft_eop} = '0;
        repeat (4) step;
    endtask

    task automatic scan;
        frame_sync = 1'b1;
        step;
        frame_sync = 1'b0;
        step;
        got[0] = line_length;
        gcnt[0] = line_cnt;
        for (int k = 1; k < 64; k++) begin
            wr_over = 1'b1;
            step;
            wr_over = 1'b0;
            step;
            got[k] = line_length;
            gcnt[k] = line_cnt;
        end
    endtask

    task automatic test_reset;
        checks += 3;
        if (line_cnt !== 7'd0) begin errors++; $display("FAIL reset_line_cnt got %0d want 0", line_cnt); end
        if (line_length !== 16'd0) begin errors++; $display("FAIL reset_line_length got %0d want 0", line_length); end
        if (frame_drop !== 1'b0) begin errors++; $display("FAIL reset_frame_drop got %b want 0", frame_drop); end
    endtask

    task automatic test_empty;
        scan;
        for (int k = 0; k < 64; k++) begin
            checks += 2;
            if (got[k] !== 16'd0) begin errors++; $display("FAIL empty_len line %0d got %0d want 0", k, got[k]); end
            if (gcnt[k] !== 7'(k)) begin errors++; $display("FAIL empty_cnt step %0d got %0d want %0d", k, gcnt[k], k); end
        end
        repeat (3) begin wr_over = 1'b1; step; wr_over = 1'b0; step; end
        checks++;
        if (line_cnt !== 7'd63) begin errors++; $display("FAIL cnt_saturate got %0d want 63", line_cnt); end
    endtask

    task automatic test_magnitude;
        fill(0, 256);
        fre[3] = -16'sd32768;
        fim[3] = -16'sd32768;
        send_bins(0, 128, 1, 1);
        scan;
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (got[k] !== ((k == 3) ? 16'd479 : 16'(4*k))) begin
                errors++; $display("FAIL magnitude line %0d got %0d want %0d", k, got[k], (k == 3) ? 479 : 4*k);
            end
        end
        frame_sync = 1'b1;
        step;
        frame_sync = 1'b0;
        checks += 4;
        if (line_length !== 16'd252) begin errors++; $display("FAIL lat_sync1 got %0d want 252", line_length); end
        step;
        if (line_length !== 16'd0) begin errors++; $display("FAIL lat_sync2 got %0d want 0", line_length); end
        wr_over = 1'b1;
        step;
        wr_over = 1'b0;
        if (line_length !== 16'd0) begin errors++; $display("FAIL lat_wr1 got %0d want 0", line_length); end
        step;
        if (line_length !== 16'd4) begin errors++; $display("FAIL lat_wr2 got %0d want 4", line_length); end
    endtask

    task automatic test_approx;
        fill(0, 0);
        fre[0] = 16'sd3000;
        fim[0] = -16'sd4000;
        send_bins(0, 128, 1, 1);
        scan;
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (got[k] !== ((k == 0) ? 16'd85 : 16'd0)) begin
                errors++; $display("FAIL approx line %0d got %0d want %0d", k, got[k], (k == 0) ? 85 : 0);
            end
        end
    endtask

    task automatic test_torn;
        fill(1000, 0);
        d0 = drops;
        send_bins(0, 60, 1, 0);
        scan;
        checks += 2;
        if (got[0] !== 16'd85 || got[1] !== 16'd0) begin
            errors++; $display("FAIL torn_old line0 %0d line1 %0d want 85 0", got[0], got[1]);
        end
        send_bins(60, 68, 0, 1);
        if (drops != d0) begin errors++; $display("FAIL torn_drop got %0d pulses want 0", drops - d0); end
        scan;
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (got[k] !== 16'd15) begin errors++; $display("FAIL torn_new line %0d got %0d want 15", k, got[k]); end
        end
    endtask

    task automatic test_drop_eop;
        fill(2000, 0);
        d0 = drops;
        send_bins(0, 51, 1, 1);
        checks++;
        if (drops - d0 != 1) begin errors++; $display("FAIL drop_eop_pulse got %0d want 1", drops - d0); end
        scan;
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (got[k] !== 16'd15) begin errors++; $display("FAIL drop_eop_noswap line %0d got %0d want 15", k, got[k]); end
        end
    endtask

    task automatic test_drop_sop;
        fill(2000, 0);
        d0 = drops;
        send_bins(0, 91, 1, 0);
        fill(0, 64);
        send_bins(0, 128, 1, 1);
        checks++;
        if (drops - d0 != 1) begin errors++; $display("FAIL drop_sop_pulse got %0d want 1", drops - d0); end
        scan;
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (got[k] !== 16'(k)) begin errors++; $display("FAIL drop_sop_restart line %0d got %0d want %0d", k, got[k], k); end
        end
    endtask

    task automatic test_priority;
        frame_sync = 1'b1;
        wr_over = 1'b1;
        step;
        frame_sync = 1'b0;
        checks += 2;
        if (line_cnt !== 7'd0) begin errors++; $display("FAIL sync_wins got %0d want 0", line_cnt); end
        step;
        wr_over = 1'b0;
        if (line_cnt !== 7'd1) begin errors++; $display("FAIL wr_over_after_sync got %0d want 1", line_cnt); end
    endtask

    task automatic test_back_to_back;
        d0 = drops;
        fill(640, 0);
        send_bins(0, 128, 1, 1);
        fill(1280, 0);
        send_bins(0, 128, 1, 1);
        checks++;
        if (drops != d0) begin errors++; $display("FAIL b2b_drop got %0d want 0", drops - d0); end
        scan;
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (got[k] !== 16'd20) begin errors++; $display("FAIL b2b_newest line %0d got %0d want 20", k, got[k]); end
        end
    endtask

    task automatic test_reset_mid;
        checks++;
        if (line_length !== 16'd20 || line_cnt !== 7'd63) begin
            errors++; $display("FAIL pre_reset len %0d cnt %0d want 20 63", line_length, line_cnt);
        end
        fill(3000, 0);
        fft_valid = 1'b1;
        fft_sop = 1'b1;
        step;
        fft_sop = 1'b0;
        repeat (10) step;
        #2;
        sys_rst = 1'b0;
        #1;
        checks += 3;
        if (line_cnt !== 7'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d want 0", line_cnt); end
        if (line_length !== 16'd0) begin errors++; $display("FAIL rst_mid_len got %0d want 0", line_length); end
        if (frame_drop !== 1'b0) begin errors++; $display("FAIL rst_mid_drop got %b want 0", frame_drop); end
        fft_valid = 1'b0;
        repeat (2) step;
        sys_rst = 1'b1;
        d0 = drops;
        repeat (4) step;
        scan;
        checks += 2;
        if (got[0] !== 16'd0 || got[40] !== 16'd0) begin
            errors++; $display("FAIL rst_mid_hidden line0 %0d line40 %0d want 0 0", got[0], got[40]);
        end
        if (drops != d0) begin errors++; $display("FAIL rst_mid_nodrop got %0d want 0", drops - d0); end
    endtask

    initial begin
        repeat (3) step;
        test_reset;
        sys_rst = 1'b1;
        step;
        test_reset;
        test_empty;
        test_magnitude;
        test_approx;
        test_torn;
        test_drop_eop;
        test_drop_sop;
        test_priority;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
